// File: rtl/mem_access_if.sv
// mem_access_if: req/ack data bus between the memory-access stage and data memory.
interface mem_access_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    modport master (output req, we, addr, sel, wdata, input ack, rdata);
    modport slave  (input req, we, addr, sel, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access.sv
// mem_access: pipeline memory-access stage; drives the data bus for loads/stores,
// stalls until ack, and aligns/extends big-endian load data for writeback.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  exm_wd,
    input  logic        exm_wreg,
    input  logic [31:0] exm_wdata,
    input  logic [3:0]  exm_memop,
    input  logic [31:0] exm_addr,
    input  logic [31:0] exm_sdata,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        stallreq,
    output logic        excp_misalign,
    mem_access_if.master dbus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t      state, state_nx;
    logic [31:0] rdata_q, ld_data;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic        is_ld, is_st, is_h, is_w, mis, go, req;

    assign is_ld = exm_memop >= 4'h1 && exm_memop <= 4'h5;
    assign is_st = exm_memop >= 4'h9 && exm_memop <= 4'hb;
    assign is_h  = exm_memop == 4'h3 || exm_memop == 4'h4 || exm_memop == 4'ha;
    assign is_w  = exm_memop == 4'h5 || exm_memop == 4'hb;
    assign mis   = (is_h & exm_addr[0]) | (is_w & |exm_addr[1:0]);
    assign go    = (is_ld | is_st) & ~mis;
    assign req   = (state == IDLE && go) || state == WAIT;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nx;

    // An ack is only meaningful while a request is outstanding.
    always_ff @(posedge clk or negedge rst)
        if (!rst)                rdata_q <= '0;
        else if (req && dbus.ack) rdata_q <= dbus.rdata;

    always_comb
        state_nx = state == IDLE ? (go ? (dbus.ack ? DONE : WAIT) : IDLE) :
                   state == WAIT ? (dbus.ack ? DONE : WAIT) : IDLE;

    // Byte offset 0 is the [31:24] lane, so shift right by 8*(3-offset).
    always_comb begin
        ld_b = 8'(rdata_q >> {~exm_addr[1:0], 3'b000});
        ld_h = exm_addr[1] ? rdata_q[15:0] : rdata_q[31:16];
        ld_data = exm_memop == 4'h1 ? {{24{ld_b[7]}}, ld_b} :
                  exm_memop == 4'h2 ? {24'h0, ld_b} :
                  exm_memop == 4'h3 ? {{16{ld_h[15]}}, ld_h} :
                  exm_memop == 4'h4 ? {16'h0, ld_h} : rdata_q;
        mem_wd        = rst ? exm_wd : 5'h0;
        mem_wreg      = rst & exm_wreg & ~is_st & ~mis;
        mem_wdata     = !rst ? 32'h0 : (state == DONE && is_ld && !mis) ? ld_data : exm_wdata;
        stallreq      = rst & req;
        excp_misalign = rst & mis;
        dbus.req      = rst & req;
        dbus.we       = rst & is_st;
        dbus.addr     = rst ? {exm_addr[31:2], 2'b00} : 32'h0;
        dbus.sel      = !rst || !(is_ld || is_st) ? 4'h0 : is_w ? 4'hf :
                        is_h ? (exm_addr[1] ? 4'b0011 : 4'b1100) : 4'b1000 >> exm_addr[1:0];
        dbus.wdata    = !rst ? 32'h0 : exm_memop == 4'h9 ? {4{exm_sdata[7:0]}} :
                        exm_memop == 4'ha ? {2{exm_sdata[15:0]}} : exm_sdata;
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed and randomized checks of mem_access against a
// byte-level big-endian reference model with a behavioural bus slave.
module tb_mem_access;
    logic        clk = 0;
    logic        rst = 0;
    logic [4:0]  exm_wd = 0;
    logic        exm_wreg = 0;
    logic [31:0] exm_wdata = 0;
    logic [3:0]  exm_memop = 0;
    logic [31:0] exm_addr = 0;
    logic [31:0] exm_sdata = 0;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        stallreq;
    logic        excp_misalign;
    int          checks = 0;
    int          errors = 0;

    mem_access_if dbus();

    mem_access dut (
        .clk(clk), .rst(rst),
        .exm_wd(exm_wd), .exm_wreg(exm_wreg), .exm_wdata(exm_wdata),
        .exm_memop(exm_memop), .exm_addr(exm_addr), .exm_sdata(exm_sdata),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .stallreq(stallreq), .excp_misalign(excp_misalign), .dbus(dbus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, direction and signedness per opcode.
    function automatic void dec(input logic [3:0] op, output int size, output bit ld,
                                output bit st, output bit sgn);
        size = 0; ld = 0; st = 0; sgn = 0;
        case (op)
            4'h1: begin size = 1; ld = 1; sgn = 1; end
            4'h2: begin size = 1; ld = 1; end
            4'h3: begin size = 2; ld = 1; sgn = 1; end
            4'h4: begin size = 2; ld = 1; end
            4'h5: begin size = 4; ld = 1; end
            4'h9: begin size = 1; st = 1; end
            4'ha: begin size = 2; st = 1; end
            4'hb: begin size = 4; st = 1; end
            default: ;
        endcase
    endfunction

    function automatic logic [3:0] exp_sel(input int size, input logic [31:0] a);
        int off = int'(a % 4);
        return 4'(((1 << size) - 1) << (4 - size - off));
    endfunction

    function automatic logic [31:0] exp_wdata(input int size, input logic [31:0] sd);
        if (size == 1) return 32'(sd[7:0]) * 32'h01010101;
        if (size == 2) return 32'(sd[15:0]) * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [31:0] exp_load(input int size, input bit sgn,
                                             input logic [31:0] a, input logic [31:0] rd);
        longint v = 0;
        int off = int'(a % 4);
        for (int i = 0; i < size; i++)
            v = v * 256 + longint'((rd >> (8 * (3 - (off + i)))) & 32'hff);
        if (sgn && v >= (longint'(1) << (8 * size - 1))) v -= longint'(1) << (8 * size);
        return 32'(v);
    endfunction

    // Aligned memory op with a bus slave that acks after `waits` idle cycles.
    task automatic do_mem(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rd, input int waits, input logic [4:0] wd,
                          input logic wreg, input logic [31:0] wdata);
        int size; bit ld, st, sgn;
        dec(op, size, ld, st, sgn);
        @(negedge clk);
        exm_memop = op; exm_addr = a; exm_sdata = sd;
        exm_wd = wd; exm_wreg = wreg; exm_wdata = wdata;
        dbus.ack = (waits == 0);
        dbus.rdata = (waits == 0) ? rd : $urandom;
        #1;
        chk("req_first", 32'(dbus.req), 1);
        chk("stall_first", 32'(stallreq), 1);
        chk("sel", 32'(dbus.sel), 32'(exp_sel(size, a)));
        chk("addr", dbus.addr, a & 32'hffff_fffc);
        chk("we", 32'(dbus.we), 32'(st));
        chk("misalign_ok", 32'(excp_misalign), 0);
        if (st) chk("wdata", dbus.wdata, exp_wdata(size, sd));
        for (int i = 1; i <= waits; i++) begin
            @(negedge clk);
            dbus.ack = (i == waits);
            dbus.rdata = (i == waits) ? rd : $urandom;
            #1;
            chk("req_wait", 32'(dbus.req), 1);
            chk("stall_wait", 32'(stallreq), 1);
        end
        @(negedge clk);
        dbus.ack = 0; dbus.rdata = $urandom;
        #1;
        chk("done_stall", 32'(stallreq), 0);
        chk("done_req", 32'(dbus.req), 0);
        chk("done_wreg", 32'(mem_wreg), st ? 0 : 32'(wreg));
        chk("done_wd", 32'(mem_wd), 32'(wd));
        chk("done_wdata", mem_wdata, ld ? exp_load(size, sgn, a, rd) : wdata);
        @(negedge clk);
        exm_memop = 0;
        #1;
        chk("after_req", 32'(dbus.req), 0);
    endtask

    // Non-memory or misaligned op: combinational pass-through, no bus activity.
    task automatic do_pass(input logic [3:0] op, input logic [31:0] a, input logic [4:0] wd,
                           input logic wreg, input logic [31:0] wdata);
        int size; bit ld, st, sgn, mis;
        dec(op, size, ld, st, sgn);
        mis = size > 1 && (a % size) != 0;
        @(negedge clk);
        exm_memop = op; exm_addr = a; exm_wd = wd; exm_wreg = wreg; exm_wdata = wdata;
        dbus.ack = 0;
        #1;
        chk("pass_misalign", 32'(excp_misalign), 32'(mis));
        chk("pass_req", 32'(dbus.req), 0);
        chk("pass_stall", 32'(stallreq), 0);
        chk("pass_wreg", 32'(mem_wreg), (mis || st) ? 0 : 32'(wreg));
        chk("pass_wd", 32'(mem_wd), 32'(wd));
        chk("pass_wdata", mem_wdata, wdata);
    endtask

    initial begin
        dbus.ack = 1; dbus.rdata = 32'hdead_beef;
        exm_memop = 4'h5; exm_addr = 32'h0000_1000; exm_sdata = 32'hffff_ffff;
        exm_wd = 5'd7; exm_wreg = 1; exm_wdata = 32'h5555_5555;
        #3;
        chk("rst_req", 32'(dbus.req), 0);
        chk("rst_stall", 32'(stallreq), 0);
        chk("rst_sel", 32'(dbus.sel), 0);
        chk("rst_addr", dbus.addr, 0);
        chk("rst_wd", 32'(mem_wd), 0);
        chk("rst_wreg", 32'(mem_wreg), 0);
        chk("rst_wdata", mem_wdata, 0);
        exm_memop = 4'hb; exm_addr = 32'h0000_1002;
        #1;
        chk("rst_we", 32'(dbus.we), 0);
        chk("rst_wdata_bus", dbus.wdata, 0);
        chk("rst_misalign", 32'(excp_misalign), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1; exm_memop = 0; dbus.ack = 0;

        do_pass(4'h0, 32'h0, 5'd5, 1, 32'h1234);
        do_mem(4'h1, 32'h1001, 32'h0, 32'h11F2_3344, 0, 5'd3, 1, 32'h0);
        do_mem(4'h4, 32'h2002, 32'h0, 32'hAAAA_8001, 3, 5'd4, 1, 32'h0);
        do_mem(4'h9, 32'h3003, 32'h0000_00A5, 32'h0, 1, 5'd6, 1, 32'h77);
        do_pass(4'h5, 32'h4002, 5'd8, 1, 32'h9999);
        do_mem(4'h3, 32'h0000_0010, 32'h0, 32'h8123_4567, 2, 5'd9, 1, 32'h0);
        do_mem(4'ha, 32'h0000_0022, 32'h0000_BEEF, 32'h0, 0, 5'd10, 1, 32'h1);

        for (int n = 0; n < 60; n++) begin
            logic [3:0] op;
            logic [31:0] a;
            int size; bit ld, st, sgn;
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            dec(op, size, ld, st, sgn);
            if (size > 0 && (a % size) == 0)
                do_mem(op, a, $urandom, $urandom, $urandom_range(0, 3), 5'($urandom),
                       1'($urandom), $urandom);
            else
                do_pass(op, a, 5'($urandom), 1'($urandom), $urandom);
        end

        @(negedge clk);
        exm_memop = 4'hb; exm_addr = 32'h0000_5004; exm_sdata = 32'h0102_0304; dbus.ack = 0;
        #1;
        chk("abort_req0", 32'(dbus.req), 1);
        @(negedge clk);
        #1;
        chk("abort_wait", 32'(dbus.req), 1);
        #2 rst = 0;
        #1;
        chk("abort_req_drop", 32'(dbus.req), 0);
        chk("abort_stall_drop", 32'(stallreq), 0);
        @(negedge clk);
        rst = 1; exm_memop = 0; dbus.ack = 1; dbus.rdata = 32'h1111_1111;
        #1;
        chk("stray_ack_req", 32'(dbus.req), 0);
        @(negedge clk);
        dbus.ack = 0; exm_memop = 4'h5; exm_addr = 32'h0000_6000; exm_wdata = 32'h0;
        #1;
        chk("idle_after_stray", 32'(dbus.req), 1);
        @(negedge clk);
        dbus.ack = 1; dbus.rdata = 32'hCAFE_F00D;
        #1;
        chk("final_wait_req", 32'(dbus.req), 1);
        @(negedge clk);
        dbus.ack = 0;
        #1;
        chk("final_load", mem_wdata, 32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
